// File: rtl/gmux_pkg.sv
// gmux_pkg: shared types and default parameters for gmux_pipe
package gmux_pkg;
   typedef enum logic [1:0] {
      MODE_FEEDBACK = 2'b00,
      MODE_HOLD     = 2'b01,
      MODE_LOAD     = 2'b10,
      MODE_CLEAR    = 2'b11
   } mode_t;
   localparam int MODE_W    = 2;
   localparam int W_DEF     = 4;
   localparam int PIPE_DEF  = 2;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/gmux_pipe_stage.sv
// pipe_stage: one valid/data register of the gmux_pipe output pipeline
module pipe_stage
   import gmux_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         vin,
   input  logic [W-1:0] din,
   output logic         vout,
   output logic [W-1:0] dout
);
   always_ff @(posedge clk)
      if (rst) begin
         vout <= 1'b0;
         dout <= '0;
      end else if (en) begin
         vout <= vin;
         dout <= din;
      end
endmodule

// File: rtl/gmux_pipe.sv
// gmux_pipe: W-lane gate/mux/feedback datapath with stalled output pipeline and beat counter
module gmux_pipe
   import gmux_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int PIPE  = PIPE_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     c,
   input  logic [W-1:0]     d,
   input  logic [MODE_W-1:0] mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     state,
   output logic [CNT_W-1:0] txn_count
);
   logic [W-1:0] k, h, g, n, m, j;
   logic         acc, stall;
   logic [PIPE:0] v;
   logic [W-1:0] dq [PIPE+1];
   mode_t        md;
   assign md = mode_t'(mode);
   always_comb begin
      h = ~(a | b);
      g = b ^ c;
      n = ~(c & d);
      m = (k & h) | (~k & g);
      j = n | m;
   end
   // global stall: a full last stage that is not taken freezes every stage
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign acc      = in_valid & in_ready;
   always_ff @(posedge clk)
      if (rst) k <= '0;
      else if (acc) k <= md == MODE_FEEDBACK ? j : md == MODE_HOLD ? k : md == MODE_LOAD ? d : '0;
   always_ff @(posedge clk)
      if (rst) txn_count <= '0;
      else if (acc) txn_count <= txn_count + 1'b1;
   assign v[0]  = acc;
   assign dq[0] = m;
   for (genvar s = 0; s < PIPE; s++) begin : g_stage
      pipe_stage #(.W(W)) u_stage (
         .clk (clk),
         .rst (rst),
         .en  (~stall),
         .vin (v[s]),
         .din (dq[s]),
         .vout(v[s+1]),
         .dout(dq[s+1])
      );
   end
   assign out_valid = v[PIPE];
   assign f         = dq[PIPE];
   assign state     = k;
endmodule

// File: tb/tb_gmux_pipe.sv
// tb_gmux_pipe: vector table, corner sequences and random scoreboard run for gmux_pipe
module tb_gmux_pipe;
   import gmux_pkg::*;
   localparam int W = 4, PIPE = 2, CNT_W = 8, N = 8;

   logic             clk = 1'b0, rst;
   logic [W-1:0]     a, b, c, d;
   logic [1:0]       mode;
   logic             in_valid, out_ready;
   logic             in_ready, out_valid;
   logic [W-1:0]     f, state;
   logic [CNT_W-1:0] txn_count;

   always #5 clk = ~clk;

   gmux_pipe #(.W(W), .PIPE(PIPE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .f(f), .out_valid(out_valid),
      .out_ready(out_ready), .state(state), .txn_count(txn_count)
   );

   typedef struct {
      logic [W-1:0] a, b, c, d;
      logic [1:0]   mode;
      logic [W-1:0] ef, es;
   } vec_t;
   vec_t tv [N];

   int           errors = 0, checks = 0, mcnt = 0, ready_lows = 0;
   logic [W-1:0] mk = '0, f_hold = '0, s0;
   logic         held = 1'b0;
   logic [W-1:0] q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, e, $time);
      end
   endtask

   // lane i: state bit high picks NOR(a,b), low picks XOR(b,c)
   function automatic logic [W-1:0] lane_out(input logic [W-1:0] kk, aa, bb, cc);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = kk[i] ? !(aa[i] || bb[i]) : (bb[i] != cc[i]);
      return r;
   endfunction

   function automatic logic [W-1:0] next_k(input logic [1:0] md, input logic [W-1:0] kk, aa, bb, cc, dd);
      logic [W-1:0] mm, r;
      mm = lane_out(kk, aa, bb, cc);
      for (int i = 0; i < W; i++)
         case (md)
            2'd0: r[i] = !(cc[i] && dd[i]) || mm[i];
            2'd1: r[i] = kk[i];
            2'd2: r[i] = dd[i];
            default: r[i] = 1'b0;
         endcase
      return r;
   endfunction

   task automatic tick(input logic iv, input logic orr, input logic [W-1:0] ta, tb, tc, td, input logic [1:0] tm);
      logic acc, hs;
      logic [W-1:0] e;
      rst = 1'b0; a = ta; b = tb; c = tc; d = td; mode = tm; in_valid = iv; out_ready = orr;
      #1;
      chk("in_ready", in_ready, !(out_valid && !orr));
      if (!in_ready) ready_lows++;
      acc = iv && in_ready;
      hs = out_valid && orr;
      held = out_valid && !orr;
      f_hold = f;
      if (hs) begin
         if (q.size() == 0) chk("spurious_out", hs, 1'b0);
         else begin
            e = q.pop_front();
            chk("f_order", f, e);
         end
      end
      if (acc) begin
         q.push_back(lane_out(mk, ta, tb, tc));
         mk = next_k(tm, mk, ta, tb, tc, td);
         mcnt = (mcnt + 1) % (1 << CNT_W);
      end
      @(posedge clk); #1;
      chk("state", state, mk);
      chk("txn_count", txn_count, mcnt[CNT_W-1:0]);
      if (held) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_f", f, f_hold);
      end
   endtask

   task automatic do_reset(input logic iv, input logic orr);
      rst = 1'b1; in_valid = iv; out_ready = orr;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      mk = '0; mcnt = 0; held = 1'b0; q.delete();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_f", f, '0);
      chk("rst_state", state, '0);
      chk("rst_txn", txn_count, '0);
      chk("rst_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1; a = '0; b = '0; c = '0; d = '0; mode = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
      tv[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 4'b1111};
      tv[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b1111, 4'b1111};
      tv[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 2'd2, 4'b1111, 4'b1010};
      tv[3] = '{4'b0000, 4'b0110, 4'b0011, 4'b1111, 2'd0, 4'b1101, 4'b1101};
      tv[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 2'd2, 4'b1101, 4'b1111};
      tv[5] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 2'd1, 4'b1010, 4'b1111};
      tv[6] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 2'd3, 4'b0011, 4'b0000};
      tv[7] = '{4'b1111, 4'b1010, 4'b0110, 4'b0000, 2'd0, 4'b1100, 4'b1111};
      @(posedge clk); #1;
      do_reset(1'b0, 1'b1);

      // back-to-back table beats: beat i shows on f after edge i+PIPE-1
      for (int i = 0; i < N + PIPE; i++) begin
         if (i < N) tick(1'b1, 1'b1, tv[i].a, tv[i].b, tv[i].c, tv[i].d, tv[i].mode);
         else tick(1'b0, 1'b1, '0, '0, '0, '0, 2'd0);
         if (i < N) chk("vec_state", state, tv[i].es);
         if (i == 1) chk("vec_txn2", txn_count, 2);
         if (i - PIPE + 1 >= 0 && i - PIPE + 1 < N) begin
            chk("vec_out_valid", out_valid, 1'b1);
            chk("vec_f", f, tv[i-PIPE+1].ef);
         end else if (i < PIPE - 1) chk("vec_latency", out_valid, 1'b0);
      end
      chk("vec_txn", txn_count, N);

      // back-pressure from cycle 3, one ignored CLEAR attempt while stalled
      do_reset(1'b0, 1'b1);
      ready_lows = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         s0 = state;
         tick(txn_count < 5, !(cyc >= 3 && cyc < 15), W'($urandom), W'($urandom), W'($urandom),
              W'(txn_count + 1), cyc == 10 ? 2'd3 : 2'd2);
         if (cyc == 10) chk("ignored_beat", state, s0);
      end
      chk("bp_txn", txn_count, 5);
      chk("bp_in_ready_dropped", ready_lows > 0, 1'b1);
      chk("bp_drained", q.size(), 0);

      // counter wrap
      do_reset(1'b0, 1'b1);
      repeat (257) tick(1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
      chk("txn_wrap", txn_count, 1);
      repeat (PIPE) tick(1'b0, 1'b1, '0, '0, '0, '0, 2'd0);
      chk("wrap_drained", q.size(), 0);

      // reset while stalled with data in flight
      do_reset(1'b0, 1'b1);
      repeat (4) tick(1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'd0);
      chk("stall_full", out_valid, 1'b1);
      do_reset(1'b1, 1'b0);
      repeat (5) begin
         tick(1'b0, 1'b1, '0, '0, '0, '0, 2'd0);
         chk("post_rst_quiet", out_valid, 1'b0);
      end

      // random traffic against the scoreboard
      do_reset(1'b0, 1'b1);
      repeat (3000)
         tick(($urandom % 4) != 0, ($urandom % 3) != 0, W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), 2'($urandom));
      repeat (PIPE + 2) tick(1'b0, 1'b1, '0, '0, '0, '0, 2'd0);
      chk("rand_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
